// File: rtl/wb_pipe_stage_pkg.sv
// Shared pipeline constants: load-width codes, link register index and the
// write-back stage state encoding.
package wb_pipe_stage_pkg;

  localparam logic [1:0] MemWidthByte = 2'b00;
  localparam logic [1:0] MemWidthHalf = 2'b01;
  localparam logic [1:0] MemWidthWord = 2'b11;

  localparam int unsigned LinkReg = 31;

  typedef enum logic {
    StRun    = 1'b0,
    StHalted = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_pipe_stage_load_extend.sv
// Combinational load extraction: picks a byte, half or word out of the raw
// memory word by byte offset and sign- or zero-extends it.
module load_extend
  import wb_pipe_stage_pkg::*;
#(
  parameter int unsigned NB_DATA = 32
) (
  input  logic [NB_DATA-1:0] mem_data,
  input  logic [1:0]         mem_width,
  input  logic [1:0]         offset,
  input  logic               mem_unsigned,
  output logic [NB_DATA-1:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = mem_data[{offset, 3'b000} +: 8];
    // Half loads ignore offset[0]; misaligned halves are not split.
    half_sel  = offset[1] ? mem_data[31:16] : mem_data[15:0];
    load_data = mem_data;
    case (mem_width)
      MemWidthByte: load_data = mem_unsigned ? NB_DATA'(byte_sel)
                                             : {{(NB_DATA-8){byte_sel[7]}}, byte_sel};
      MemWidthHalf: load_data = mem_unsigned ? NB_DATA'(half_sel)
                                             : {{(NB_DATA-16){half_sel[15]}}, half_sel};
      default:      load_data = mem_data;
    endcase
  end

endmodule

// File: rtl/wb_pipe_stage.sv
// Write-back pipeline stage: registers the MEM-stage entry, selects the
// register-file write data, tracks HALT and counts retired instructions.
module wb_pipe_stage
  import wb_pipe_stage_pkg::*;
#(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_REG  = 5,
  parameter int unsigned NB_PC   = 32,
  parameter int unsigned NB_CNT  = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic               i_reg_write,
  input  logic               i_mem_to_reg,
  input  logic               i_last_register_ctrl,
  input  logic               i_halt,
  input  logic [1:0]         i_mem_width,
  input  logic               i_mem_unsigned,
  input  logic [NB_DATA-1:0] i_mem_data,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic [NB_REG-1:0]  i_selected_reg,
  input  logic [NB_PC-1:0]   i_pc,
  output logic               o_reg_write,
  output logic [NB_DATA-1:0] o_selected_data,
  output logic [NB_REG-1:0]  o_selected_reg,
  output logic               o_valid,
  output logic               o_halted,
  output logic [NB_CNT-1:0]  o_retired_count
);

  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic               mem_to_reg;
    logic               link;
    logic               halt;
    logic [1:0]         mem_width;
    logic               mem_unsigned;
    logic [NB_DATA-1:0] mem_data;
    logic [NB_DATA-1:0] alu_result;
    logic [NB_REG-1:0]  sel_reg;
    logic [NB_PC-1:0]   pc;
  } stage_t;

  stage_t             stage_q, stage_d, capture;
  wb_state_e          state_q, state_d;
  logic [NB_CNT-1:0]  count_q, count_d;
  logic [NB_DATA-1:0] load_data;

  always_comb begin
    capture = '{
      valid:        i_valid,
      reg_write:    i_reg_write,
      mem_to_reg:   i_mem_to_reg,
      link:         i_last_register_ctrl,
      halt:         i_halt,
      mem_width:    i_mem_width,
      mem_unsigned: i_mem_unsigned,
      mem_data:     i_mem_data,
      alu_result:   i_alu_result,
      sel_reg:      i_selected_reg,
      pc:           i_pc
    };
    stage_d = stage_q;
    state_d = state_q;
    count_d = count_q;
    if (i_enable) begin
      // Once halted the stage drains to a bubble and never captures again.
      if (state_q == StHalted || i_flush) begin
        stage_d = '0;
      end else if (!i_stall) begin
        stage_d = capture;
        if (i_valid) begin
          count_d = count_q + NB_CNT'(1);
          if (i_halt) state_d = StHalted;
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      stage_q <= '0;
      state_q <= StRun;
      count_q <= '0;
    end else begin
      stage_q <= stage_d;
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  load_extend #(
    .NB_DATA (NB_DATA)
  ) u_load_extend (
    .mem_data     (stage_q.mem_data),
    .mem_width    (stage_q.mem_width),
    .offset       (stage_q.alu_result[1:0]),
    .mem_unsigned (stage_q.mem_unsigned),
    .load_data    (load_data)
  );

  always_comb begin
    o_selected_reg = stage_q.link ? NB_REG'(LinkReg) : stage_q.sel_reg;
    if (stage_q.link)            o_selected_data = NB_DATA'(stage_q.pc);
    else if (stage_q.mem_to_reg) o_selected_data = load_data;
    else                         o_selected_data = stage_q.alu_result;
    o_reg_write     = stage_q.valid & stage_q.reg_write & ~stage_q.halt & (|o_selected_reg);
    o_valid         = stage_q.valid;
    o_halted        = (state_q == StHalted);
    o_retired_count = count_q;
  end

endmodule

// File: doc/wb_pipe_stage.md
WB_PIPE_STAGE -- requirements
Module: wb_pipe_stage

Interface
REQ-001 Parameters SHALL be: NB_DATA, default 32, datapath width; NB_REG, default 5, register-index width; NB_PC, default 32, PC width (NB_PC <= NB_DATA); NB_CNT, default 32, retire-counter width.
REQ-002 i_clock  in  1  sole clock, rising edge.
REQ-003 i_reset  in  1  synchronous, active-low reset.
REQ-004 i_enable  in  1  global step enable from the debug unit; 0 freezes all state.
REQ-005 i_stall  in  1  hold the stage register.
REQ-006 i_flush  in  1  load a bubble.
REQ-007 i_valid  in  1  incoming MEM-stage entry is a real instruction.
REQ-008 i_reg_write, i_mem_to_reg, i_last_register_ctrl, i_halt  in  1 each  control bits: write enable, memory-data select, link (JAL/JALR) select, HALT instruction.
REQ-009 i_mem_width  in  2  load size: 00 byte, 01 half, 11 word, 10 treated as word.
REQ-010 i_mem_unsigned  in  1  1 zero-extends, 0 sign-extends.
REQ-011 i_mem_data, i_alu_result  in  NB_DATA  raw memory word, ALU result; i_alu_result[1:0] is the load byte offset.
REQ-012 i_selected_reg  in  NB_REG  destination; i_pc  in  NB_PC  return address, already offset upstream.
REQ-013 o_reg_write  out  1; o_selected_data  out  NB_DATA; o_selected_reg  out  NB_REG  register-file write port.
REQ-014 o_valid  out  1; o_halted  out  1; o_retired_count  out  NB_CNT.

Function
REQ-015 Stage register SHALL update on rising edge only when i_enable=1 and FSM=RUN; priority i_flush (bubble: valid=0, all controls 0) > i_stall (hold) > capture all inputs.
REQ-016 All outputs SHALL derive from the stage register only; input-to-output latency exactly 1 cycle.
REQ-017 o_selected_data SHALL be: link=1 -> zero-extended captured pc; else mem_to_reg=1 -> extracted load data; else alu_result.
REQ-018 Load extraction: byte -> data[8*off+7 : 8*off]; half -> off[1]=0 low half, 1 high half, off[0] ignored; word -> full data; extend to NB_DATA per i_mem_unsigned.
REQ-019 o_selected_reg SHALL be all-ones (r31) when link=1, else captured selected_reg.
REQ-020 o_reg_write SHALL equal valid & reg_write & !halt-entry & (o_selected_reg != 0).
REQ-021 FSM states RUN, HALTED; RUN->HALTED on the edge capturing i_valid=1 & i_halt=1 & !i_flush; HALTED->RUN only via reset.
REQ-022 In HALTED, first edge with i_enable=1 SHALL clear the stage register to bubble; no further captures; o_halted=1 from the cycle the halt entry is displayed onward.
REQ-023 o_retired_count SHALL increment by 1 on each edge that captures a valid entry (halt included); wraps modulo 2^NB_CNT; stall/flush/bubble captures do not count.
REQ-024 Simultaneous i_flush and i_halt SHALL flush: no halt, no count.

Reset
REQ-025 While i_reset=0 at an edge, irrespective of i_enable: stage register bubble, FSM=RUN, counter 0; hence all outputs 0.
REQ-026 Reset mid-stall or in HALTED SHALL behave identically to REQ-025.

Structure
REQ-027 Width-code constants (byte/half/word), FSM state encoding and link register index 31 SHALL live in the shared pipeline package.
REQ-028 Load extraction SHALL be one combinational sub-module, load_extend.

Verification
REQ-029 alu=0xBB, mem=0xAA, mem_to_reg=0, reg_write=1, reg=5 -> next cycle data=0xBB, reg=5, o_reg_write=1; mem_to_reg=1 -> 0xAA.
REQ-030 mem=0x8081_82F3, byte, off=3, signed -> 0xFFFF_FF80; unsigned -> 0x0000_0080; half off=2 signed -> 0xFFFF_8081.
REQ-031 link=1, pc=0x0000_0108 -> data=0x108, reg=31; reg=0 with reg_write=1, link=0 -> o_reg_write=0.
REQ-032 Stall 3 cycles mid-stream -> outputs held, count unchanged; flush -> o_valid=0, o_reg_write=0.
REQ-033 Halt after 4 valid entries -> o_halted=1, count=5, later inputs ignored; reset low -> all outputs 0, FSM RUN.
REQ-034 NB_CNT=4, 17 valid captures -> count=1 (wrap).
